// File: rtl/run_controller.sv
// ---------------------------------------------------------------------------
// run_controller
//   Run controller for the single-cycle core. After a start pulse it holds the
//   core in reset for RESET_CYCLES cycles and then releases it. While the core
//   runs it counts cycles and retired instructions. The run ends either when
//   the core writes a value with bit 0 set to TOHOST_ADDR, or when the cycle
//   budget MAX_CYCLES runs out. Done, pass and the exit code are reported.
//
// Ports
//   i_clk            rising-edge clock
//   i_rst            synchronous active-high reset
//   i_start          1-cycle pulse: begin or restart a run
//   i_mem_we         core data-memory write enable (snooped)
//   i_mem_addr       core data-memory address (snooped)
//   i_mem_wdata      core data-memory write data (snooped)
//   i_retire         core retired an instruction this cycle
//   o_core_rst_n     active-low reset driven to the core
//   o_running        high while in RUN
//   o_cycle_count    RUN cycles elapsed (saturating)
//   o_instret_count  retire pulses seen in RUN (saturating)
//   o_done           run finished, held until start or reset
//   o_pass           finished via tohost with exit code 0
//   o_timeout        finished via cycle budget exhaustion
//   o_exit_code      mem_wdata >> 1 of the terminating tohost write
// ---------------------------------------------------------------------------
module run_controller #(
  parameter int                    RESET_CYCLES = 4,
  parameter int                    MAX_CYCLES   = 1000,
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] TOHOST_ADDR  = 'h100,
  parameter int                    CNT_WIDTH    = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_mem_we,
  input  logic [ADDR_WIDTH-1:0] i_mem_addr,
  input  logic [DATA_WIDTH-1:0] i_mem_wdata,
  input  logic                  i_retire,
  output logic                  o_core_rst_n,
  output logic                  o_running,
  output logic [CNT_WIDTH-1:0]  o_cycle_count,
  output logic [CNT_WIDTH-1:0]  o_instret_count,
  output logic                  o_done,
  output logic                  o_pass,
  output logic                  o_timeout,
  output logic [DATA_WIDTH-2:0] o_exit_code
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RESET = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int RC_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [RC_W-1:0]      RC_LOAD = RC_W'(RESET_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_CYCLES);

  logic [1:0]            r_state;
  logic [RC_W-1:0]       r_rst_cnt;
  logic                  r_core_rst_n;
  logic                  r_running;
  logic [CNT_WIDTH-1:0]  r_cycle_count;
  logic [CNT_WIDTH-1:0]  r_instret_count;
  logic                  r_done;
  logic                  r_pass;
  logic                  r_timeout;
  logic [DATA_WIDTH-2:0] r_exit_code;

  logic                  w_tohost;
  logic                  w_budget_hit;
  logic [CNT_WIDTH-1:0]  w_cycle_inc;
  logic [CNT_WIDTH-1:0]  w_instret_inc;
  logic [DATA_WIDTH-2:0] w_code;

  // Writes with bit 0 clear are console traffic and never end the run.
  assign w_tohost = (r_state == S_RUN) && i_mem_we &&
                    (i_mem_addr == TOHOST_ADDR) && i_mem_wdata[0];
  assign w_code   = i_mem_wdata[DATA_WIDTH-1:1];

  // Counters stick at all-ones instead of wrapping.
  assign w_cycle_inc   = (r_cycle_count == '1) ? r_cycle_count
                                               : r_cycle_count + CNT_WIDTH'(1);
  assign w_instret_inc = (r_instret_count == '1) ? r_instret_count
                                                 : r_instret_count + CNT_WIDTH'(1);

  // The budget is hit on the edge that makes the cycle count equal MAX_CYCLES.
  assign w_budget_hit = (w_cycle_inc == MAX_CNT);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state         <= S_IDLE;
      r_rst_cnt       <= '0;
      r_core_rst_n    <= 1'b0;
      r_running       <= 1'b0;
      r_cycle_count   <= '0;
      r_instret_count <= '0;
      r_done          <= 1'b0;
      r_pass          <= 1'b0;
      r_timeout       <= 1'b0;
      r_exit_code     <= '0;
    end else if (i_start) begin
      // start from any state (re)enters RESET with a clean slate
      r_state         <= S_RESET;
      r_rst_cnt       <= RC_LOAD;
      r_core_rst_n    <= 1'b0;
      r_running       <= 1'b0;
      r_cycle_count   <= '0;
      r_instret_count <= '0;
      r_done          <= 1'b0;
      r_pass          <= 1'b0;
      r_timeout       <= 1'b0;
      r_exit_code     <= '0;
    end else begin
      case (r_state)
        S_RESET: begin
          if (r_rst_cnt == '0) begin
            r_state      <= S_RUN;
            r_core_rst_n <= 1'b1;
            r_running    <= 1'b1;
          end else begin
            r_rst_cnt <= r_rst_cnt - RC_W'(1);
          end
        end
        S_RUN: begin
          r_cycle_count <= w_cycle_inc;
          if (i_retire) begin
            r_instret_count <= w_instret_inc;
          end
          // tohost takes priority over a budget hit on the same edge
          if (w_tohost) begin
            r_state      <= S_DONE;
            r_core_rst_n <= 1'b0;
            r_running    <= 1'b0;
            r_done       <= 1'b1;
            r_exit_code  <= w_code;
            r_pass       <= (w_code == '0);
          end else if (w_budget_hit) begin
            r_state      <= S_DONE;
            r_core_rst_n <= 1'b0;
            r_running    <= 1'b0;
            r_done       <= 1'b1;
            r_timeout    <= 1'b1;
          end
        end
        S_IDLE, S_DONE: begin
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_core_rst_n    = r_core_rst_n;
  assign o_running       = r_running;
  assign o_cycle_count   = r_cycle_count;
  assign o_instret_count = r_instret_count;
  assign o_done          = r_done;
  assign o_pass          = r_pass;
  assign o_timeout       = r_timeout;
  assign o_exit_code     = r_exit_code;

endmodule

// File: tb/tb_run_controller.sv
// ---------------------------------------------------------------------------
// tb_run_controller
//   Self-checking bench for run_controller with RESET_CYCLES=4, MAX_CYCLES=20,
//   TOHOST_ADDR=0x100. Inputs change and outputs are sampled on the falling
//   clock edge. A table of single-cycle write patterns is applied in the first
//   RUN cycle of a fresh run; multi-cycle cases are written out by hand.
// ---------------------------------------------------------------------------
module tb_run_controller;

  localparam int RESET_CYCLES = 4;
  localparam int MAX_CYCLES   = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        memWe;
  logic [31:0] memAddr;
  logic [31:0] memWdata;
  logic        retire;
  logic        coreRstN;
  logic        running;
  logic [31:0] cycleCount;
  logic [31:0] instretCount;
  logic        done;
  logic        pass;
  logic        timeout;
  logic [30:0] exitCode;

  int testsRun    = 0;
  int testsFailed = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        retire;
    logic        expDone;
    logic        expPass;
    logic [30:0] expExit;
    logic        expRunning;
    logic [31:0] expInstret;
  } vec_t;

  vec_t vecs[9];

  run_controller #(
    .RESET_CYCLES(RESET_CYCLES),
    .MAX_CYCLES  (MAX_CYCLES),
    .ADDR_WIDTH  (32),
    .DATA_WIDTH  (32),
    .TOHOST_ADDR (32'h100),
    .CNT_WIDTH   (32)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_start        (start),
    .i_mem_we       (memWe),
    .i_mem_addr     (memAddr),
    .i_mem_wdata    (memWdata),
    .i_retire       (retire),
    .o_core_rst_n   (coreRstN),
    .o_running      (running),
    .o_cycle_count  (cycleCount),
    .o_instret_count(instretCount),
    .o_done         (done),
    .o_pass         (pass),
    .o_timeout      (timeout),
    .o_exit_code    (exitCode)
  );

  always #5 clk = ~clk;

  // one rising edge, then return at the following falling edge
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic st, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic ret);
    start    = st;
    memWe    = we;
    memAddr  = addr;
    memWdata = wdata;
    retire   = ret;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic doStart();
    applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  // called right after the start edge: expects exactly RESET_CYCLES low samples
  task automatic checkResetWindow(input string tag);
    for (int i = 0; i < RESET_CYCLES; i++) begin
      checkOutput($sformatf("%s.rstLow%0d", tag, i), {63'd0, coreRstN}, 64'd0);
      tick();
    end
    checkOutput({tag, ".rstHigh"}, {63'd0, coreRstN}, 64'd1);
    checkOutput({tag, ".running"}, {63'd0, running}, 64'd1);
  endtask

  // bounded wait for RUN after a start pulse
  task automatic enterRun(input string tag);
    for (int i = 0; i < 16 && !running; i++) tick();
    checkOutput({tag, ".enterRun"}, {63'd0, running}, 64'd1);
  endtask

  task automatic checkZero(input string tag);
    checkOutput({tag, ".coreRstN"}, {63'd0, coreRstN}, 64'd0);
    checkOutput({tag, ".running"},  {63'd0, running},  64'd0);
    checkOutput({tag, ".cycle"},    {32'd0, cycleCount},   64'd0);
    checkOutput({tag, ".instret"},  {32'd0, instretCount}, 64'd0);
    checkOutput({tag, ".done"},     {63'd0, done},     64'd0);
    checkOutput({tag, ".pass"},     {63'd0, pass},     64'd0);
    checkOutput({tag, ".timeout"},  {63'd0, timeout},  64'd0);
    checkOutput({tag, ".exit"},     {33'd0, exitCode}, 64'd0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 32'h100, 32'h1,        1'b1, 1'b1, 1'b1, 31'h0,        1'b0, 32'd1};
    vecs[1] = '{1'b1, 32'h100, 32'h7,        1'b0, 1'b1, 1'b0, 31'h3,        1'b0, 32'd0};
    vecs[2] = '{1'b1, 32'h100, 32'h40,       1'b1, 1'b0, 1'b0, 31'h0,        1'b1, 32'd1};
    vecs[3] = '{1'b1, 32'h104, 32'h1,        1'b0, 1'b0, 1'b0, 31'h0,        1'b1, 32'd0};
    vecs[4] = '{1'b0, 32'h100, 32'h1,        1'b1, 1'b0, 1'b0, 31'h0,        1'b1, 32'd1};
    vecs[5] = '{1'b1, 32'h100, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, 31'h7FFFFFFF, 1'b0, 32'd1};
    vecs[6] = '{1'b1, 32'h100, 32'h80000001, 1'b0, 1'b1, 1'b0, 31'h40000000, 1'b0, 32'd0};
    vecs[7] = '{1'b1, 32'h000, 32'h3,        1'b1, 1'b0, 1'b0, 31'h0,        1'b1, 32'd1};
    vecs[8] = '{1'b1, 32'h1100, 32'h1,       1'b0, 1'b0, 1'b0, 31'h0,        1'b1, 32'd0};

    // reset state, then exact reset window length
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    tick();
    checkZero("rst");
    rst = 1'b0;
    tick();
    checkOutput("idle.coreRstN", {63'd0, coreRstN}, 64'd0);
    doStart();
    checkResetWindow("t1");
    checkOutput("t1.cycle0", {32'd0, cycleCount}, 64'd0);

    // 10 retiring cycles, then a passing tohost write that also retires
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      tick();
    end
    applyStimulus(1'b0, 1'b1, 32'h100, 32'h1, 1'b1);
    tick();
    checkOutput("t2.done",     {63'd0, done}, 64'd1);
    checkOutput("t2.pass",     {63'd0, pass}, 64'd1);
    checkOutput("t2.exit",     {33'd0, exitCode}, 64'd0);
    checkOutput("t2.cycle",    {32'd0, cycleCount}, 64'd11);
    checkOutput("t2.instret",  {32'd0, instretCount}, 64'd11);
    checkOutput("t2.coreRstN", {63'd0, coreRstN}, 64'd0);
    // counters and result hold in DONE; writes there are ignored
    applyStimulus(1'b0, 1'b1, 32'h100, 32'h7, 1'b1);
    tick();
    tick();
    checkOutput("t2.holdCycle",   {32'd0, cycleCount}, 64'd11);
    checkOutput("t2.holdInstret", {32'd0, instretCount}, 64'd11);
    checkOutput("t2.holdExit",    {33'd0, exitCode}, 64'd0);
    checkOutput("t2.holdDone",    {63'd0, done}, 64'd1);

    // table: one write pattern applied in the first RUN cycle of a fresh run
    for (int i = 0; i < 9; i++) begin
      doStart();
      enterRun($sformatf("vec%0d", i));
      applyStimulus(1'b0, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].retire);
      tick();
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      checkOutput($sformatf("vec%0d.done", i),    {63'd0, done}, {63'd0, vecs[i].expDone});
      checkOutput($sformatf("vec%0d.pass", i),    {63'd0, pass}, {63'd0, vecs[i].expPass});
      checkOutput($sformatf("vec%0d.exit", i),    {33'd0, exitCode}, {33'd0, vecs[i].expExit});
      checkOutput($sformatf("vec%0d.running", i), {63'd0, running}, {63'd0, vecs[i].expRunning});
      checkOutput($sformatf("vec%0d.instret", i), {32'd0, instretCount}, {32'd0, vecs[i].expInstret});
      checkOutput($sformatf("vec%0d.cycle", i),   {32'd0, cycleCount}, 64'd1);
      checkOutput($sformatf("vec%0d.timeout", i), {63'd0, timeout}, 64'd0);
    end

    // console write then failing exit code in the same run
    doStart();
    enterRun("t3");
    applyStimulus(1'b0, 1'b1, 32'h100, 32'h40, 1'b0);
    tick();
    checkOutput("t3.consoleRunning", {63'd0, running}, 64'd1);
    checkOutput("t3.consoleDone",    {63'd0, done}, 64'd0);
    applyStimulus(1'b0, 1'b1, 32'h100, 32'h7, 1'b0);
    tick();
    checkOutput("t3.done", {63'd0, done}, 64'd1);
    checkOutput("t3.pass", {63'd0, pass}, 64'd0);
    checkOutput("t3.exit", {33'd0, exitCode}, 64'd3);

    // cycle budget runs out
    doStart();
    enterRun("t4a");
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < MAX_CYCLES - 1; i++) tick();
    checkOutput("t4a.preRunning", {63'd0, running}, 64'd1);
    checkOutput("t4a.preCycle",   {32'd0, cycleCount}, 64'd19);
    tick();
    checkOutput("t4a.done",    {63'd0, done}, 64'd1);
    checkOutput("t4a.timeout", {63'd0, timeout}, 64'd1);
    checkOutput("t4a.pass",    {63'd0, pass}, 64'd0);
    checkOutput("t4a.cycle",   {32'd0, cycleCount}, 64'd20);
    checkOutput("t4a.exit",    {33'd0, exitCode}, 64'd0);

    // tohost on the budget edge wins
    doStart();
    enterRun("t4b");
    for (int i = 0; i < MAX_CYCLES - 1; i++) tick();
    applyStimulus(1'b0, 1'b1, 32'h100, 32'h1, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    checkOutput("t4b.done",    {63'd0, done}, 64'd1);
    checkOutput("t4b.timeout", {63'd0, timeout}, 64'd0);
    checkOutput("t4b.pass",    {63'd0, pass}, 64'd1);
    checkOutput("t4b.cycle",   {32'd0, cycleCount}, 64'd20);

    // reset mid-run (start ignored while reset is high)
    doStart();
    enterRun("t5");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      tick();
    end
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 1'b1);
    tick();
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    checkZero("t5rst");
    tick();
    tick();
    checkOutput("t5.idleCoreRstN", {63'd0, coreRstN}, 64'd0);
    checkOutput("t5.idleRunning",  {63'd0, running}, 64'd0);

    // start from DONE clears everything and gives a full reset window
    doStart();
    enterRun("t5b");
    applyStimulus(1'b0, 1'b1, 32'h100, 32'h7, 1'b1);
    tick();
    checkOutput("t5b.exit", {33'd0, exitCode}, 64'd3);
    doStart();
    checkOutput("t5b.clrDone",    {63'd0, done}, 64'd0);
    checkOutput("t5b.clrExit",    {33'd0, exitCode}, 64'd0);
    checkOutput("t5b.clrCycle",   {32'd0, cycleCount}, 64'd0);
    checkOutput("t5b.clrInstret", {32'd0, instretCount}, 64'd0);
    checkResetWindow("t5b");

    // foreign-address writes do nothing; start mid-run restarts
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      tick();
    end
    applyStimulus(1'b0, 1'b1, 32'h200, 32'h1, 1'b1);
    tick();
    checkOutput("t6.running", {63'd0, running}, 64'd1);
    checkOutput("t6.cycle",   {32'd0, cycleCount}, 64'd6);
    checkOutput("t6.instret", {32'd0, instretCount}, 64'd6);
    doStart();
    checkOutput("t6.rsCycle",    {32'd0, cycleCount}, 64'd0);
    checkOutput("t6.rsInstret",  {32'd0, instretCount}, 64'd0);
    checkOutput("t6.rsRunning",  {63'd0, running}, 64'd0);
    checkOutput("t6.rsCoreRstN", {63'd0, coreRstN}, 64'd0);
    // start while already in RESET reloads the window
    tick();
    tick();
    doStart();
    checkResetWindow("t6");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
